// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative 32-cycle multiply/divide sequencer beside the EX-stage ALU.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op[1:0]     request (IDLE only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[31:0], b[31:0]   multiplicand/dividend, multiplier/divisor
//   flush              abort current or pending operation
//   stall, busy, done  pipeline hold, FSM active, one-cycle result strobe
//   hi[31:0], lo[31:0] product high/low or remainder/quotient
//   div_zero           last completed op was a divide by zero
// Build option: define MULDIV_DIV_EN to build the divide datapath; otherwise
// divide ops complete immediately with hi = lo = 0 and div_zero = 1.
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);
  localparam logic [2:0] IDLE = 3'd0, PREP = 3'd1, CALC = 3'd2, FIX = 3'd3, DONE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d, prod_fix;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d, neg_q, neg_d, dz_q, dz_d;
  logic [32:0] msum;
  assign busy     = (state_q == PREP) | (state_q == CALC) | (state_q == FIX);
  assign stall    = busy | ((state_q == IDLE) & start & ~flush);
  assign done     = state_q == DONE;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  // Multiply: acc holds {partial high, product bits shifted in from the top}; b_q shifts right.
  assign msum     = {1'b0, acc_q[63:32]} + {1'b0, b_q[0] ? a_q : 32'd0};
  assign prod_fix = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d, nrem_q, nrem_d;
  logic [33:0] diff;
  // Divide: partial remainder in acc[63:32], quotient bits shift into acc[31:0],
  // dividend bits feed from the top of a_q. diff[33] set means the trial subtract borrowed.
  assign diff = {1'b0, acc_q[63:32], a_q[31]} - {2'b0, b_q};
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    nrem_d  = nrem_q;
`endif
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        a_d   = a;
        b_d   = b;
        sgn_d = ~op[0];
`ifdef MULDIV_DIV_EN
        div_d = op[1];
        if (op[1] && b == 32'd0) begin
          state_d = DONE;
          hi_d    = a;
          lo_d    = '1;
          dz_d    = 1'b1;
        end else state_d = PREP;
`else
        if (op[1]) begin
          state_d = DONE;
          hi_d    = 32'd0;
          lo_d    = 32'd0;
          dz_d    = 1'b1;
        end else state_d = PREP;
`endif
      end
      PREP: begin
        a_d     = (sgn_q & a_q[31]) ? -a_q : a_q;
        b_d     = (sgn_q & b_q[31]) ? -b_q : b_q;
        neg_d   = sgn_q & (a_q[31] ^ b_q[31]);
`ifdef MULDIV_DIV_EN
        nrem_d  = sgn_q & a_q[31];
`endif
        acc_d   = 64'd0;
        cnt_d   = 5'd0;
        state_d = CALC;
      end
      CALC: begin
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? FIX : CALC;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          a_d   = a_q << 1;
          acc_d = {diff[33] ? {acc_q[62:32], a_q[31]} : diff[31:0], acc_q[30:0], ~diff[33]};
        end else begin
          acc_d = {msum, acc_q[31:1]};
          b_d   = b_q >> 1;
        end
`else
        acc_d = {msum, acc_q[31:1]};
        b_d   = b_q >> 1;
`endif
      end
      FIX: begin
        state_d = DONE;
        dz_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        // Quotient and remainder carry independent signs.
        if (div_q) begin
          lo_d = neg_q ? -acc_q[31:0] : acc_q[31:0];
          hi_d = nrem_q ? -acc_q[63:32] : acc_q[63:32];
        end else {hi_d, lo_d} = prod_fix;
`else
        {hi_d, lo_d} = prod_fix;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 1'b0;
      nrem_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      nrem_q <= nrem_d;
    end
  end
`endif
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench for ex_muldiv_ctrl.
module tb_ex_muldiv_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [64:0] exp_q[$];
  logic [64:0] e;
  int          checks = 0, failures = 0;

  ex_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done hi=%h lo=%h dz=%b", hi, lo, div_zero);
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e[64:33]});
        chk("result_lo", {32'd0, lo}, {32'd0, e[32:1]});
        chk("result_dz", {63'd0, div_zero}, {63'd0, e[0]});
      end
    end
  end

  // Issue one op at cycle 0; optionally pulse a stray divide-by-zero start at cycle poke.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed,
                     input int lat, input int poke);
    int n, stall_lo;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back({eh, el, ed});
    @(negedge clk);
    chk("stall_cycle0", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    stall_lo = 0;
    while (!done && n < 100) begin
      if (!stall) stall_lo++;
      if (n == poke) begin
        start = 1'b1; op = 2'b11; b = 32'd0;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_latency", 64'(n), 64'(lat));
    chk("stall_low_while_busy", 64'(stall_lo), 64'd0);
    chk("stall_at_done", {63'd0, stall}, 64'd0);
  endtask

  initial begin
    #2;
    chk("reset_outs", {59'd0, stall, busy, done, div_zero, |{hi, lo}}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35, 0);
    run(2'b00, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35, 0);
`ifdef MULDIV_DIV_EN
    run(2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35, 0);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 35, 0);
    run(2'b11, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1, 1, 0);
    run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, 0);
`else
    run(2'b10, -32'sd7, 32'd2, 32'h0, 32'h0, 1'b1, 1, 0);
    run(2'b11, 32'd100, 32'd0, 32'h0, 32'h0, 1'b1, 1, 0);
`endif
    run(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 35, 0);

    // Flush at cycle 10 of a MULT: no done, hi/lo kept.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {62'd0, busy, stall}, 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("flush_keeps_result", {hi, lo}, 64'd6);

    // start together with flush in IDLE is refused.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd4; b = 32'd4;
    @(negedge clk);
    chk("start_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'd0, busy}, 64'd0);

    // Stray start during CALC is ignored.
    run(2'b01, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0, 35, 20);
    repeat (40) @(posedge clk);

    // Reset at cycle 20 of a long op clears every output at once.
    @(posedge clk); #1;
`ifdef MULDIV_DIV_EN
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
`else
    start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd3;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outs", {stall, busy, done, div_zero, 28'd0, hi | lo}, 64'd0);
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
